// File: rtl/scarv_cop_mp_seq.sv
// Multi-precision limb sequencer: turns one N-limb add/sub command into per-limb
// add3.mp / sub3.mp MALU operations over consecutive CPRs, carrying between limbs.
module scarv_cop_mp_seq #(
  parameter logic [3:0] SCLASS_ADD3 = 4'h3,
  parameter logic [3:0] SCLASS_SUB3 = 4'h5
) (
  input  logic        g_clk,
  input  logic        g_resetn,

  input  logic        seq_req,
  output logic        seq_ready,
  input  logic        seq_op,
  input  logic [3:0]  seq_ra,
  input  logic [3:0]  seq_rb,
  input  logic [3:0]  seq_rd,
  input  logic [4:0]  seq_len,
  input  logic        seq_cin,
  output logic        seq_done,
  output logic        seq_cout,

  output logic [3:0]  rf_raddr1,
  output logic [3:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,

  output logic        malu_ivalid,
  output logic [3:0]  malu_subclass,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  input  logic        malu_idone,
  input  logic [3:0]  malu_cpr_rd_ben,
  input  logic [31:0] malu_cpr_rd_wdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [3:0]  rd_q, rd_d;
  logic [4:0]  len_q, len_d;
  logic        carry_q, carry_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  wb_cnt_q, wb_cnt_d;

  logic [4:0]  idx_inc;
  logic [3:0]  limb;

  assign idx_inc  = idx_q + 5'd1;
  assign limb     = idx_q[3:0];
  // The carry register only moves during EXEC, so after DONE it holds the result
  // until the next accept reloads it with cin.
  assign seq_cout = carry_q;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ra_d          = ra_q;
    rb_d          = rb_q;
    rd_d          = rd_q;
    len_d         = len_q;
    carry_d       = carry_q;
    idx_d         = idx_q;
    a_d           = a_q;
    b_d           = b_q;
    wb_cnt_d      = wb_cnt_q;

    seq_ready     = 1'b0;
    seq_done      = 1'b0;
    rf_raddr1     = 4'd0;
    rf_raddr2     = 4'd0;
    rf_we         = 1'b0;
    rf_waddr      = 4'd0;
    rf_wdata      = 32'd0;
    malu_ivalid   = 1'b0;
    malu_subclass = 4'd0;
    malu_rs1      = 32'd0;
    malu_rs2      = 32'd0;
    malu_rs3      = 32'd0;

    unique case (state_q)
      ST_IDLE: begin
        seq_ready = 1'b1;
        if (seq_req) begin
          op_d    = seq_op;
          ra_d    = seq_ra;
          rb_d    = seq_rb;
          rd_d    = seq_rd;
          len_d   = seq_len;
          carry_d = seq_cin;
          idx_d   = 5'd0;
          state_d = (seq_len == 5'd0) ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Operands are captured here, before any write of this limb, so rd may alias ra/rb.
        rf_raddr1 = ra_q + limb;
        rf_raddr2 = rb_q + limb;
        a_d       = rf_rdata1;
        b_d       = rf_rdata2;
        wb_cnt_d  = 2'd0;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        malu_ivalid   = 1'b1;
        malu_subclass = op_q ? SCLASS_SUB3 : SCLASS_ADD3;
        malu_rs1      = a_q;
        malu_rs2      = b_q;
        malu_rs3      = {31'd0, carry_q};

        // First written word is the result limb, second is the carry/borrow word.
        if (malu_cpr_rd_ben == 4'hF) begin
          if (wb_cnt_q == 2'd0) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q + limb;
            rf_wdata = malu_cpr_rd_wdata;
            wb_cnt_d = 2'd1;
          end else if (wb_cnt_q == 2'd1) begin
            carry_d  = (malu_cpr_rd_wdata != 32'd0);
            wb_cnt_d = 2'd2;
          end
        end

        if (malu_idone) begin
          idx_d   = idx_inc;
          state_d = (idx_inc < len_q) ? ST_LOAD : ST_DONE;
        end
      end

      ST_DONE: begin
        seq_done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= 1'b0;
      ra_q     <= 4'd0;
      rb_q     <= 4'd0;
      rd_q     <= 4'd0;
      len_q    <= 5'd0;
      carry_q  <= 1'b0;
      idx_q    <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      wb_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rd_q     <= rd_d;
      len_q    <= len_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wb_cnt_q <= wb_cnt_d;
    end
  end

endmodule

// File: tb/tb_scarv_cop_mp_seq.sv
// Bench for scarv_cop_mp_seq: behavioural CPR file and MALU, and a limb-by-limb
// arithmetic reference model of each command.
module tb_scarv_cop_mp_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        seq_req = 1'b0;
  logic        seq_ready;
  logic        seq_op = 1'b0;
  logic [3:0]  seq_ra = '0, seq_rb = '0, seq_rd = '0;
  logic [4:0]  seq_len = '0;
  logic        seq_cin = 1'b0;
  logic        seq_done, seq_cout;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;
  logic        malu_ivalid, malu_idone;
  logic [3:0]  malu_subclass, malu_cpr_rd_ben;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3, malu_cpr_rd_wdata;

  scarv_cop_mp_seq dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .seq_req(seq_req), .seq_ready(seq_ready), .seq_op(seq_op),
    .seq_ra(seq_ra), .seq_rb(seq_rb), .seq_rd(seq_rd), .seq_len(seq_len),
    .seq_cin(seq_cin), .seq_done(seq_done), .seq_cout(seq_cout),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .malu_ivalid(malu_ivalid), .malu_subclass(malu_subclass),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_idone(malu_idone), .malu_cpr_rd_ben(malu_cpr_rd_ben),
    .malu_cpr_rd_wdata(malu_cpr_rd_wdata)
  );

  always #5 g_clk = ~g_clk;

  // CPR file: combinational read, written by the DUT or bulk-loaded by the bench.
  logic [31:0] cpr     [16];
  logic [31:0] init_val[16];
  logic [31:0] ref_cpr [16];
  logic        do_load = 1'b0;

  assign rf_rdata1 = cpr[rf_raddr1];
  assign rf_rdata2 = cpr[rf_raddr2];

  always @(posedge g_clk) begin
    if (do_load) cpr <= init_val;
    else if (rf_we) cpr[rf_waddr] <= rf_wdata;
  end

  // MALU: low word on EXEC cycle 2, high word plus idone on cycle 3.
  int unsigned ex_cnt = 0;
  always @(posedge g_clk) begin
    if (!malu_ivalid || malu_idone) ex_cnt <= 0;
    else ex_cnt <= ex_cnt + 1;
  end

  logic [32:0] m_res;
  logic [31:0] m_hi;
  always_comb begin
    if (malu_subclass == 4'h5) begin
      m_res = {1'b0, malu_rs1} - {1'b0, malu_rs2} - {1'b0, malu_rs3};
      m_hi  = m_res[32] ? 32'hFFFF_FFFF : 32'd0;
    end else begin
      m_res = {1'b0, malu_rs1} + {1'b0, malu_rs2} + {1'b0, malu_rs3};
      m_hi  = {31'd0, m_res[32]};
    end
    malu_idone        = malu_ivalid && (ex_cnt == 2);
    malu_cpr_rd_ben   = (malu_ivalid && (ex_cnt == 1 || ex_cnt == 2)) ? 4'hF : 4'h0;
    malu_cpr_rd_wdata = (ex_cnt == 1) ? m_res[31:0] : m_hi;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: limb-serial multi-precision add/sub on ref_cpr.
  logic       exp_rs3[$];
  logic [3:0] exp_wa [$];

  task automatic ref_run(input bit op, input logic [3:0] ra, rb, rd, input int len,
                         input bit cin, output bit cout);
    bit c = cin;
    exp_rs3.delete();
    exp_wa.delete();
    for (int i = 0; i < len; i++) begin
      logic [31:0] a, b, r;
      longint      d;
      a = ref_cpr[(int'(ra) + i) % 16];
      b = ref_cpr[(int'(rb) + i) % 16];
      exp_rs3.push_back(c);
      exp_wa.push_back(4'((int'(rd) + i) % 16));
      if (op) d = longint'(a) - longint'(b) - longint'(c);
      else    d = longint'(a) + longint'(b) + longint'(c);
      r = 32'(d);
      c = op ? (d < 0) : (d > 64'h0000_0000_FFFF_FFFF);
      ref_cpr[(int'(rd) + i) % 16] = r;
    end
    cout = c;
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 16; i++) init_val[i] = $urandom;
  endtask

  task automatic preload();
    @(negedge g_clk);
    do_load = 1'b1;
    ref_cpr = init_val;
    @(negedge g_clk);
    do_load = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_cpr%0d", tag, i), {32'd0, cpr[i]}, {32'd0, ref_cpr[i]});
  endtask

  task automatic drive_cmd(input bit op, input logic [3:0] ra, rb, rd, input int len, input bit cin);
    seq_req = 1'b1; seq_op = op; seq_ra = ra; seq_rb = rb; seq_rd = rd;
    seq_len = 5'(len); seq_cin = cin;
  endtask

  // Runs one command from the IDLE state; k counts cycles after the accept cycle T.
  task automatic run_cmd(input string tag, input bit op, input logic [3:0] ra, rb, rd,
                         input int len, input bit cin, input bit hold);
    bit         exp_cout;
    int         done_k = -1, ndone = 0, wcnt = 0, ivcnt = 0;
    logic       got_rs3[$];
    logic [3:0] got_wa [$];
    ref_run(op, ra, rb, rd, len, cin, exp_cout);
    @(negedge g_clk);
    check({tag, "_ready_pre"}, {63'd0, seq_ready}, 64'd1);
    drive_cmd(op, ra, rb, rd, len, cin);
    for (int k = 1; k <= 4 * len + 2; k++) begin
      @(negedge g_clk);
      if (!hold) seq_req = 1'b0;
      if ((k % 4) == 1 && (k - 1) / 4 < len) begin
        check($sformatf("%s_raddr1_%0d", tag, (k - 1) / 4), {60'd0, rf_raddr1},
              64'((int'(ra) + (k - 1) / 4) % 16));
        check($sformatf("%s_raddr2_%0d", tag, (k - 1) / 4), {60'd0, rf_raddr2},
              64'((int'(rb) + (k - 1) / 4) % 16));
      end
      if (rf_we) begin wcnt++; got_wa.push_back(rf_waddr); end
      if (malu_ivalid) ivcnt++;
      if (malu_idone) got_rs3.push_back(malu_rs3[0]);
      if (seq_done) begin
        ndone++;
        if (done_k < 0) done_k = k;
        check({tag, "_cout"}, {63'd0, seq_cout}, {63'd0, exp_cout});
        seq_req = 1'b0;
      end
      if (k == 4 * len + 2) begin
        check({tag, "_ready_post"}, {63'd0, seq_ready}, 64'd1);
        check({tag, "_cout_held"}, {63'd0, seq_cout}, {63'd0, exp_cout});
      end
    end
    seq_req = 1'b0;
    check({tag, "_done_cycle"}, 64'(done_k), 64'(4 * len + 1));
    check({tag, "_done_count"}, 64'(ndone), 64'd1);
    check({tag, "_wr_count"}, 64'(wcnt), 64'(len));
    check({tag, "_ivalid_cycles"}, 64'(ivcnt), 64'(3 * len));
    for (int i = 0; i < len && i < got_wa.size(); i++)
      check($sformatf("%s_waddr_%0d", tag, i), {60'd0, got_wa[i]}, {60'd0, exp_wa[i]});
    for (int i = 0; i < len && i < got_rs3.size(); i++)
      check($sformatf("%s_rs3_%0d", tag, i), {63'd0, got_rs3[i]}, {63'd0, exp_rs3[i]});
    check_regs(tag);
  endtask

  initial begin
    rand_regs();
    repeat (3) @(negedge g_clk);
    check("rst_ready", {63'd0, seq_ready}, 64'd1);
    check("rst_done", {63'd0, seq_done}, 64'd0);
    check("rst_cout", {63'd0, seq_cout}, 64'd0);
    check("rst_ivalid", {63'd0, malu_ivalid}, 64'd0);
    check("rst_we", {63'd0, rf_we}, 64'd0);
    g_resetn = 1'b1;
    preload();

    // Single-limb add with carry out.
    rand_regs(); init_val[0] = 32'hFFFF_FFFF; init_val[1] = 32'h1;
    preload();
    run_cmd("add1", 1'b0, 4'd0, 4'd1, 4'd2, 1, 1'b0, 1'b0);

    // Four-limb carry ripple.
    rand_regs();
    for (int i = 0; i < 4; i++) init_val[i] = 32'hFFFF_FFFF;
    init_val[4] = 32'd1; init_val[5] = 32'd0; init_val[6] = 32'd0; init_val[7] = 32'd0;
    preload();
    run_cmd("ripple", 1'b0, 4'd0, 4'd4, 4'd8, 4, 1'b0, 1'b0);

    // Two-limb subtract with borrow into the second limb.
    rand_regs();
    init_val[0] = 32'd0; init_val[1] = 32'd1; init_val[2] = 32'd1; init_val[3] = 32'd0;
    preload();
    run_cmd("sub2", 1'b1, 4'd0, 4'd2, 4'd4, 2, 1'b0, 1'b0);

    // Zero-length command passes cin straight through.
    run_cmd("len0", 1'b0, 4'd3, 4'd5, 4'd7, 0, 1'b1, 1'b0);

    // Wrapping in-place add with seq_req held high while busy.
    rand_regs(); preload();
    run_cmd("wrap", 1'b0, 4'd14, 4'd2, 4'd14, 4, 1'b0, 1'b1);

    // Reset during EXEC of limb 1 of a three-limb command.
    begin
      bit dummy;
      int wcnt = 0, ndone = 0;
      rand_regs(); preload();
      ref_run(1'b0, 4'd0, 4'd4, 4'd8, 1, 1'b0, dummy);
      @(negedge g_clk);
      drive_cmd(1'b0, 4'd0, 4'd4, 4'd8, 3, 1'b0);
      for (int k = 1; k <= 24; k++) begin
        @(negedge g_clk);
        seq_req = 1'b0;
        if (rf_we) wcnt++;
        if (seq_done) ndone++;
        if (k == 6) g_resetn = 1'b0;
        if (k == 7) begin
          check("abort_ivalid", {63'd0, malu_ivalid}, 64'd0);
          check("abort_ready", {63'd0, seq_ready}, 64'd1);
          check("abort_cout", {63'd0, seq_cout}, 64'd0);
          g_resetn = 1'b1;
        end
      end
      check("abort_wr_count", 64'(wcnt), 64'd1);
      check("abort_done_count", 64'(ndone), 64'd0);
      check_regs("abort");
    end

    // Randomized commands.
    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 0) begin rand_regs(); preload(); end
      run_cmd($sformatf("rnd%0d", n), 1'($urandom), 4'($urandom), 4'($urandom),
              4'($urandom), int'($urandom_range(0, 16)), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scarv_cop_mp_seq.md
# scarv_cop_mp_seq

Multi-precision limb sequencer for the coprocessor. It takes one command, an N-limb add or subtract over consecutive coprocessor registers, and issues per-limb `add3.mp` / `sub3.mp` operations to the MALU. Between limbs it carries the borrow/carry word forward. It reads source limbs from the CPR file, writes the result limbs back, and returns the final normalised carry.

## Interface
Parameters:
- SCLASS_ADD3, 4'h3, subclass code driven for add limbs
- SCLASS_SUB3, 4'h5, subclass code driven for sub limbs

Ports:
- g_clk  in  1  clock; all state changes on the rising edge
- g_resetn  in  1  reset, synchronous, active-low
- seq_req  in  1  command request; accepted on the cycle where seq_req && seq_ready
- seq_ready  out  1  high only in IDLE
- seq_op  in  1  0 = add, 1 = subtract
- seq_ra, seq_rb, seq_rd  in  4 each  base register of A, B and D
- seq_len  in  5  limb count, 0..16
- seq_cin  in  1  initial carry (add) or borrow (sub)
- seq_done  out  1  one-cycle pulse when the command completes
- seq_cout  out  1  final carry/borrow; valid while seq_done is high and held until the next accept
- rf_raddr1, rf_raddr2  out  4 each  CPR read addresses; read data is combinational
- rf_rdata1, rf_rdata2  in  32 each  CPR read data
- rf_we  out  1  CPR write enable
- rf_waddr  out  4  CPR write address
- rf_wdata  out  32  CPR write data
- malu_ivalid  out  1  MALU instruction valid
- malu_subclass  out  4  MALU subclass
- malu_rs1, malu_rs2, malu_rs3  out  32 each  MALU operands
- malu_idone  in  1  MALU instruction complete
- malu_cpr_rd_ben  in  4  MALU writeback byte enable; 4'hF marks a written word
- malu_cpr_rd_wdata  in  32  MALU writeback data

## Operation
- States: IDLE, LOAD, EXEC, DONE.
- On accept, the block latches op, ra, rb, rd, len and cin. The carry register is set to cin and the limb index i is set to 0.
  - len = 0: go to DONE.
  - Otherwise: go to LOAD.
- LOAD:
  - Drive rf_raddr1 = ra+i and rf_raddr2 = rb+i.
  - Latch rf_rdata1/2 into the operand registers.
  - Clear the writeback counter.
  - Go to EXEC.
- EXEC:
  - Drive malu_ivalid = 1.
  - malu_subclass = SCLASS_ADD3 for add, SCLASS_SUB3 for sub.
  - malu_rs1 = A[i], malu_rs2 = B[i], malu_rs3 = {31'b0, carry}.
  - All operands stay stable for the whole of EXEC.
- Writeback capture during EXEC, on each cycle with malu_cpr_rd_ben == 4'hF:
  - First word (low): rf_we = 1, rf_waddr = rd+i, rf_wdata = malu_cpr_rd_wdata, all in the same cycle.
  - Second word (high): carry <= (malu_cpr_rd_wdata != 0). No rf write.
- On malu_idone in EXEC:
  - i <= i+1.
  - Go to LOAD if i+1 < len, else go to DONE.
- DONE:
  - seq_done = 1 and seq_cout = carry.
  - Next state is IDLE.
- Address arithmetic is 4-bit and wraps modulo 16: ra=14 gives 14, 15, 0, 1, ...
- Aliasing rules:
  - rd == ra or rd == rb is legal, because operands are latched in LOAD before any write to the same limb.
  - Overlapping ranges with a different offset produce sequential-order semantics.
- seq_req is ignored when seq_ready is low. There is no queueing.
- Outputs outside their active state:
  - malu_ivalid, rf_we and seq_done are 0.
  - Address and data outputs are don't-care, but the implementation drives them to 0.

## Timing
- Reset, while g_resetn is low at a clock edge:
  - State goes to IDLE.
  - seq_ready = 1 after the edge.
  - seq_done = 0, seq_cout = 0, malu_ivalid = 0, rf_we = 0.
  - carry, i and the operand registers are 0.
- Reset applied mid-command aborts it: no further rf_we, ivalid drops after the reset edge, and no seq_done is produced.
- Accept at cycle T:
  - LOAD for limb 0 at T+1.
  - EXEC for limb 0 at T+2..T+4, since the MALU add3/sub3 takes 3 cycles with idone on the 3rd.
  - Low-word write at T+3; high word captured at T+4.
  - Each subsequent limb adds 4 cycles.
- seq_done at T+4·len+1, and seq_ready is high again at T+4·len+2.
- For len = 0: seq_done at T+1, seq_cout = cin, and no MALU or RF activity.
- Each limb produces exactly one rf write, so a command produces len rf writes in total.
- The MALU is always presented with valid for the full operation. The block never deasserts malu_ivalid before malu_idone.

## Test plan
Use a behavioural MALU model that writes the low word on EXEC cycle 2, the high word on cycle 3, and asserts idone on cycle 3.

- Single-limb add carry: add, len=1, A=0xFFFFFFFF, B=0x1, cin=0 -> R[rd]=0x0, seq_cout=1, seq_done at T+5, exactly one rf_we.
- Add ripple: add, len=4, A limbs all 0xFFFFFFFF, B limbs = 1, 0, 0, 0 -> D limbs all 0, seq_cout=1, malu_rs3 per limb = 0, 1, 1, 1, seq_done at T+17.
- Sub borrow: sub, len=2, A limbs = 0x0, 0x1 and B limbs = 0x1, 0x0 -> D limbs = 0xFFFFFFFF, 0x0, seq_cout=0, second-limb rs3 = 1.
- Zero length: len=0, cin=1 -> seq_done at T+1, seq_cout=1, no malu_ivalid, no rf_we, seq_ready high at T+2.
- Wrap and alias: add, ra=rd=14, rb=2, len=4 -> reads 14, 15, 0, 1 and writes 14, 15, 0, 1 in place with correct sums. seq_req held high during busy is ignored.
- Reset mid-op: assert g_resetn=0 in EXEC of limb 1 of a len=3 command -> after the edge, ivalid=0, ready=1, and no seq_done. Limb 0's write remains; no limb 2 write occurs.
